// File: rtl/t2mi_pkg.sv
// Shared definitions for the T2-MI BBFrame data-field path: scheduler state
// encoding, the "no user packet" SYNCD marker and the user-packet start indices.
package t2mi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   localparam logic [15:0] SYNCD_NONE = 16'hFFFF;

   // In high-efficiency mode the sync byte is stripped, so a packet starts at index 1
   localparam logic [7:0] UP_IDX_NM  = 8'd0;
   localparam logic [7:0] UP_IDX_HEM = 8'd1;

   localparam int DFL_MAX_BYTES_DEFAULT = 7274;

   function automatic logic [7:0] up_index(input logic hem);
      return hem ? UP_IDX_HEM : UP_IDX_NM;
   endfunction

endpackage

// File: rtl/data_field_sched_syncd_capture.sv
// First-match latch of the bit offset of the first user-packet start seen in
// a data field. Holds SYNCD_NONE until a match, then ignores later matches.
module syncd_capture
   import t2mi_pkg::*;
#(
   parameter int CNT_W = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             valid,
   input  logic             hem,
   input  logic [7:0]       byte_index,
   input  logic [CNT_W-1:0] received,
   output logic [15:0]      syncd
);

   logic found;

   // Latch received*8 on the first valid byte whose index marks a packet start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncd <= SYNCD_NONE;
         found <= 1'b0;
      end else if (clear) begin
         syncd <= SYNCD_NONE;
         found <= 1'b0;
      end else if (valid && !found && (byte_index == up_index(hem))) begin
         syncd <= 16'({received, 3'b000});
         found <= 1'b1;
      end
   end

endmodule

// File: rtl/data_field_sched.sv
// Builds one BBFrame data field per START: reads DFL bytes from the TS FIFO,
// frames them with SOF/EOF and reports SYNCD one cycle after the last byte.
module data_field_sched
   import t2mi_pkg::*;
#(
   parameter int DFL_MAX_BYTES = DFL_MAX_BYTES_DEFAULT,
   parameter int CNT_W         = 13
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [CNT_W-1:0] DFL_BYTES,
   input  logic             NM_OR_HEM,
   input  logic             FIFO_EMPTY,
   input  logic [7:0]       FIFO_DATA,
   input  logic [7:0]       FIFO_BYTE_INDEX,
   output logic             RD_REQ,
   output logic [7:0]       DATA_OUT,
   output logic             DVALID_OUT,
   output logic             SOF,
   output logic             EOF,
   output logic [15:0]      SYNCD,
   output logic             SYNCD_VALID,
   output logic             BUSY,
   output logic             ERR
);

   localparam logic [CNT_W-1:0] DFL_MAX_CNT = CNT_W'(DFL_MAX_BYTES);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

   state_t           state;
   logic [CNT_W-1:0] dfl;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] received;
   logic             hem;
   logic             dvalid;
   logic             busy;
   logic             err;
   logic             syncd_valid;

   logic start_ok;
   logic accept;
   logic rd_req;
   logic last_issue;
   logic sof_now;
   logic eof_now;

   assign start_ok   = START && (DFL_BYTES != CNT_ZERO) && (DFL_BYTES <= DFL_MAX_CNT);
   assign accept     = (state == ST_IDLE) && start_ok;
   // Reads stop exactly at the latched length, so the counters never wrap
   assign rd_req     = (state == ST_READ) && !FIFO_EMPTY && (issued != dfl);
   assign last_issue = rd_req && (issued == (dfl - CNT_ONE));
   assign sof_now    = dvalid && (received == CNT_ZERO);
   assign eof_now    = dvalid && (received == (dfl - CNT_ONE));

   // Field sequencing: accept/reject START, issue reads, wait for EOF, report
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= ST_IDLE;
         dfl         <= CNT_ZERO;
         hem         <= 1'b0;
         issued      <= CNT_ZERO;
         busy        <= 1'b0;
         err         <= 1'b0;
         syncd_valid <= 1'b0;
      end else begin
         err         <= 1'b0;
         syncd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  if (start_ok) begin
                     dfl    <= DFL_BYTES;
                     hem    <= NM_OR_HEM;
                     issued <= CNT_ZERO;
                     busy   <= 1'b1;
                     state  <= ST_READ;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (rd_req) begin
                  issued <= issued + CNT_ONE;
               end
               if (last_issue) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (eof_now) begin
                  syncd_valid <= 1'b1;
                  state       <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // FIFO q is valid one cycle after the request; count bytes as they arrive
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         dvalid   <= 1'b0;
         received <= CNT_ZERO;
      end else begin
         dvalid <= rd_req;
         if (accept) begin
            received <= CNT_ZERO;
         end else if (dvalid) begin
            received <= received + CNT_ONE;
         end
      end
   end

   syncd_capture #(
      .CNT_W (CNT_W)
   ) u_syncd_capture (
      .clk        (CLK),
      .rst_n      (RST),
      .clear      (accept),
      .valid      (dvalid),
      .hem        (hem),
      .byte_index (FIFO_BYTE_INDEX),
      .received   (received),
      .syncd      (SYNCD)
   );

   assign RD_REQ      = rd_req;
   assign DVALID_OUT  = dvalid;
   assign DATA_OUT    = dvalid ? FIFO_DATA : 8'h00;
   assign SOF         = sof_now;
   assign EOF         = eof_now;
   assign SYNCD_VALID = syncd_valid;
   assign BUSY        = busy;
   assign ERR         = err;

endmodule

// File: tb/tb_data_field_sched.sv
// Bench for data_field_sched: a queue-based FIFO model feeds the DUT, a
// monitor collects each field, and expectations come from the loaded words.
module tb_data_field_sched;

   localparam int CNT_W   = 13;
   localparam int DFL_MAX = 7274;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             START = 1'b0;
   logic [CNT_W-1:0] DFL_BYTES = '0;
   logic             NM_OR_HEM = 1'b0;
   logic             FIFO_EMPTY = 1'b1;
   logic [7:0]       FIFO_DATA = 8'h00;
   logic [7:0]       FIFO_BYTE_INDEX = 8'h00;
   logic             RD_REQ;
   logic [7:0]       DATA_OUT;
   logic             DVALID_OUT;
   logic             SOF;
   logic             EOF;
   logic [15:0]      SYNCD;
   logic             SYNCD_VALID;
   logic             BUSY;
   logic             ERR;

   data_field_sched #(
      .DFL_MAX_BYTES (DFL_MAX),
      .CNT_W         (CNT_W)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .START           (START),
      .DFL_BYTES       (DFL_BYTES),
      .NM_OR_HEM       (NM_OR_HEM),
      .FIFO_EMPTY      (FIFO_EMPTY),
      .FIFO_DATA       (FIFO_DATA),
      .FIFO_BYTE_INDEX (FIFO_BYTE_INDEX),
      .RD_REQ          (RD_REQ),
      .DATA_OUT        (DATA_OUT),
      .DVALID_OUT      (DVALID_OUT),
      .SOF             (SOF),
      .EOF             (EOF),
      .SYNCD           (SYNCD),
      .SYNCD_VALID     (SYNCD_VALID),
      .BUSY            (BUSY),
      .ERR             (ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] idx;
   } word_t;

   word_t      fifo_q[$];
   word_t      exp_q[$];
   logic [7:0] got_data[$];

   int n_tests = 0;
   int n_fail  = 0;

   int cyc, rd_cnt, rd_empty_cnt, busy_cyc, err_cnt;
   int sof_cnt, eof_cnt, sof_at, eof_at, eof_cyc, first_dv_cyc, first_rd_cyc;
   int sv_cnt, sv_cyc;
   logic [15:0] sv_syncd;
   logic        busy_at_sv;
   int n_reads, stall_at, stall_len, stall_left;
   bit rand_stall = 1'b0;
   bit timed_out;

   task automatic clear_mon();
      got_data.delete();
      cyc = 0; rd_cnt = 0; rd_empty_cnt = 0; busy_cyc = 0; err_cnt = 0;
      sof_cnt = 0; eof_cnt = 0; sof_at = -1; eof_at = -1; eof_cyc = -1;
      first_dv_cyc = -1; first_rd_cyc = -1;
      sv_cnt = 0; sv_cyc = -1; sv_syncd = 16'h0000; busy_at_sv = 1'b0;
      n_reads = 0; stall_left = 0;
      timed_out = 1'b0;
   endtask

   // One clock: observe outputs at the falling edge, model the FIFO after the rising edge
   task automatic tick();
      logic  pop;
      word_t w;
      @(negedge CLK);
      cyc++;
      if (RD_REQ) begin
         rd_cnt++;
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (RD_REQ && FIFO_EMPTY) rd_empty_cnt++;
      if (BUSY) busy_cyc++;
      if (ERR) err_cnt++;
      if (DVALID_OUT) begin
         got_data.push_back(DATA_OUT);
         if (first_dv_cyc < 0) first_dv_cyc = cyc;
      end
      if (SOF) begin sof_cnt++; sof_at = got_data.size() - 1; end
      if (EOF) begin eof_cnt++; eof_at = got_data.size() - 1; eof_cyc = cyc; end
      if (SYNCD_VALID) begin
         sv_cnt++; sv_cyc = cyc; sv_syncd = SYNCD; busy_at_sv = BUSY;
      end
      pop = RD_REQ && !FIFO_EMPTY && (fifo_q.size() > 0);
      @(posedge CLK);
      #1;
      START = 1'b0;
      if (pop) begin
         w = fifo_q.pop_front();
         FIFO_DATA = w.data;
         FIFO_BYTE_INDEX = w.idx;
         n_reads++;
         if (n_reads == stall_at) stall_left = stall_len;
      end
      if (stall_left > 0) begin
         FIFO_EMPTY = 1'b1;
         stall_left--;
      end else if (rand_stall && ($urandom_range(0, 3) == 0)) begin
         FIFO_EMPTY = 1'b1;
      end else begin
         FIFO_EMPTY = (fifo_q.size() == 0);
      end
   endtask

   // Fill the FIFO with n words; byte indices follow the TS packet cycle 0..187
   task automatic load(input int n, input int first_idx);
      word_t w;
      fifo_q.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         w.data = 8'($urandom);
         w.idx  = 8'((first_idx + i) % 188);
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
      FIFO_EMPTY = (fifo_q.size() == 0);
   endtask

   // SYNCD from the field's rule: 8 * position of the first packet-start index
   function automatic logic [15:0] ref_syncd(input int dfl, input bit hem);
      for (int i = 0; i < dfl; i++) begin
         if (exp_q[i].idx == (hem ? 8'd1 : 8'd0)) return 16'(i * 8);
      end
      return 16'hFFFF;
   endfunction

   function automatic int data_errors(input int dfl);
      int bad = 0;
      for (int i = 0; i < dfl; i++) begin
         if (i >= got_data.size()) bad++;
         else if (got_data[i] !== exp_q[i].data) bad++;
      end
      return bad;
   endfunction

   // Request one field and clock until SYNCD_VALID; optionally pulse START again mid-field
   task automatic run_field(input int dfl, input bit hem, input int poke_at);
      int budget;
      clear_mon();
      budget = 8 * dfl + 60;
      DFL_BYTES = CNT_W'(dfl);
      NM_OR_HEM = hem;
      START = 1'b1;
      while (sv_cnt == 0 && cyc < budget) begin
         tick();
         if (cyc == poke_at) begin
            START = 1'b1;
            DFL_BYTES = CNT_W'(3);
            NM_OR_HEM = !hem;
         end
      end
      timed_out = (sv_cnt == 0);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      #23;
      n_tests++;
      if ({RD_REQ, DVALID_OUT, SOF, EOF, SYNCD_VALID, BUSY, ERR, DATA_OUT, SYNCD} !== {7'b0, 8'h00, 16'hFFFF}) begin
         n_fail++;
         $display("FAIL reset_state: got rd=%b dv=%b sof=%b eof=%b sv=%b busy=%b err=%b data=%h syncd=%h, expected zeros and syncd=ffff",
                  RD_REQ, DVALID_OUT, SOF, EOF, SYNCD_VALID, BUSY, ERR, DATA_OUT, SYNCD);
      end
      @(posedge CLK);
      #1;
      RST = 1'b1;
      tick();
   endtask

   task automatic test_nm_basic();
      load(13, 185);
      run_field(10, 1'b0, -1);
      n_tests++;
      if (timed_out) begin n_fail++; $display("FAIL nm_timeout: no SYNCD_VALID within budget"); end
      n_tests++;
      if (got_data.size() != 10 || data_errors(10) != 0) begin
         n_fail++; $display("FAIL nm_data: got %0d bytes, %0d wrong, expected 10 bytes", got_data.size(), data_errors(10));
      end
      n_tests++;
      if (sof_cnt != 1 || sof_at != 0 || eof_cnt != 1 || eof_at != 9) begin
         n_fail++; $display("FAIL nm_framing: sof %0d@%0d eof %0d@%0d, expected 1@0 and 1@9", sof_cnt, sof_at, eof_cnt, eof_at);
      end
      n_tests++;
      if (sv_syncd !== 16'd24 || sv_syncd !== ref_syncd(10, 1'b0)) begin
         n_fail++; $display("FAIL nm_syncd: got %0d expected 24", sv_syncd);
      end
      n_tests++;
      if (sv_cyc != eof_cyc + 1 || sv_cnt != 1 || busy_at_sv !== 1'b1) begin
         n_fail++; $display("FAIL nm_report: sv at %0d (count %0d, busy %b), eof at %0d, expected sv one cycle after eof with busy",
                            sv_cyc, sv_cnt, busy_at_sv, eof_cyc);
      end
      n_tests++;
      if (eof_cyc - first_dv_cyc != 9 || fifo_q.size() != 3) begin
         n_fail++; $display("FAIL nm_contiguous: span %0d, words left %0d, expected span 9 and 3 left", eof_cyc - first_dv_cyc, fifo_q.size());
      end
      tick();
      n_tests++;
      if (SYNCD !== 16'd24 || BUSY !== 1'b0) begin
         n_fail++; $display("FAIL nm_hold: syncd %0d busy %b after report, expected 24 and 0", SYNCD, BUSY);
      end
   endtask

   task automatic test_hem();
      load(8, 180);
      run_field(8, 1'b1, -1);
      n_tests++;
      if (timed_out || got_data.size() != 8 || data_errors(8) != 0) begin
         n_fail++; $display("FAIL hem_data: got %0d bytes, timeout %b, expected 8", got_data.size(), timed_out);
      end
      n_tests++;
      if (sv_syncd !== 16'hFFFF) begin
         n_fail++; $display("FAIL hem_nomatch: got syncd %h expected ffff", sv_syncd);
      end
      tick();
      // indices 186,187,0,1,...: index 0 must not count in HEM, so the match is byte 3
      load(6, 186);
      run_field(6, 1'b1, -1);
      n_tests++;
      if (timed_out || sv_syncd !== ref_syncd(6, 1'b1)) begin
         n_fail++; $display("FAIL hem_idx0: got syncd %0d expected %0d", sv_syncd, ref_syncd(6, 1'b1));
      end
   endtask

   task automatic test_stall();
      load(7, $urandom_range(0, 187));
      stall_at = 2;
      stall_len = 3;
      run_field(5, 1'b0, -1);
      stall_at = 0;
      n_tests++;
      if (rd_empty_cnt != 0) begin
         n_fail++; $display("FAIL stall_rd_while_empty: got %0d cycles expected 0", rd_empty_cnt);
      end
      n_tests++;
      if (timed_out || got_data.size() != 5 || data_errors(5) != 0 || rd_cnt != 5) begin
         n_fail++; $display("FAIL stall_data: got %0d bytes, %0d reads, expected 5 and 5", got_data.size(), rd_cnt);
      end
      n_tests++;
      if (eof_cnt != 1 || eof_at != 4 || eof_cyc - first_dv_cyc != 7) begin
         n_fail++; $display("FAIL stall_eof: eof %0d@%0d span %0d, expected 1@4 span 7", eof_cnt, eof_at, eof_cyc - first_dv_cyc);
      end
      tick();
   endtask

   task automatic test_err();
      int bad_len[3] = '{0, DFL_MAX + 1, (1 << CNT_W) - 1};
      for (int k = 0; k < 3; k++) begin
         load(4, 0);
         clear_mon();
         DFL_BYTES = CNT_W'(bad_len[k]);
         START = 1'b1;
         repeat (3) tick();
         n_tests++;
         if (err_cnt != 1 || busy_cyc != 0 || rd_cnt != 0) begin
            n_fail++; $display("FAIL err_len%0d: err %0d busy %0d reads %0d, expected 1 0 0", bad_len[k], err_cnt, busy_cyc, rd_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      load(3, 0);
      run_field(1, 1'b0, 2);
      n_tests++;
      if (timed_out || got_data.size() != 1 || data_errors(1) != 0 || err_cnt != 0) begin
         n_fail++; $display("FAIL single_data: got %0d bytes err %0d, expected 1 byte no err", got_data.size(), err_cnt);
      end
      n_tests++;
      if (sof_cnt != 1 || eof_cnt != 1 || sof_at != 0 || eof_at != 0 || sv_syncd !== 16'd0) begin
         n_fail++; $display("FAIL single_framing: sof %0d eof %0d syncd %0d, expected 1 1 0", sof_cnt, eof_cnt, sv_syncd);
      end
      // next field starts in the cycle right after SYNCD_VALID
      load(6, 187);
      run_field(4, 1'b0, -1);
      n_tests++;
      if (timed_out || first_rd_cyc != 2 || got_data.size() != 4 || data_errors(4) != 0) begin
         n_fail++; $display("FAIL b2b_start: first read at %0d, %0d bytes, expected 2 and 4", first_rd_cyc, got_data.size());
      end
      n_tests++;
      if (sv_syncd !== ref_syncd(4, 1'b0)) begin
         n_fail++; $display("FAIL b2b_syncd: got %0d expected %0d", sv_syncd, ref_syncd(4, 1'b0));
      end
      tick();
   endtask

   task automatic test_reset_mid();
      load(15, $urandom_range(0, 187));
      clear_mon();
      DFL_BYTES = CNT_W'(10);
      NM_OR_HEM = 1'b0;
      START = 1'b1;
      while (got_data.size() < 3 && cyc < 40) tick();
      n_tests++;
      if (got_data.size() != 3) begin
         n_fail++; $display("FAIL midrst_progress: got %0d bytes expected 3", got_data.size());
      end
      #2;
      RST = 1'b0;
      #1;
      n_tests++;
      if ({RD_REQ, DVALID_OUT, SOF, EOF, SYNCD_VALID, BUSY, ERR, DATA_OUT, SYNCD} !== {7'b0, 8'h00, 16'hFFFF}) begin
         n_fail++; $display("FAIL midrst_outputs: rd=%b dv=%b busy=%b sv=%b syncd=%h, expected zeros and ffff",
                            RD_REQ, DVALID_OUT, BUSY, SYNCD_VALID, SYNCD);
      end
      repeat (3) tick();
      n_tests++;
      if (eof_cnt != 0 || sv_cnt != 0) begin
         n_fail++; $display("FAIL midrst_abandon: eof %0d sv %0d, expected 0 0", eof_cnt, sv_cnt);
      end
      RST = 1'b1;
      tick();
      load(12, 184);
      run_field(10, 1'b1, -1);
      n_tests++;
      if (timed_out || got_data.size() != 10 || data_errors(10) != 0 || eof_at != 9 || sv_syncd !== ref_syncd(10, 1'b1)) begin
         n_fail++; $display("FAIL midrst_next: %0d bytes eof@%0d syncd %0d, expected 10 9 %0d", got_data.size(), eof_at, sv_syncd, ref_syncd(10, 1'b1));
      end
      tick();
   endtask

   task automatic test_max_len();
      load(DFL_MAX + 1, $urandom_range(0, 187));
      run_field(DFL_MAX, 1'b0, -1);
      n_tests++;
      if (timed_out || got_data.size() != DFL_MAX || data_errors(DFL_MAX) != 0 || eof_at != DFL_MAX - 1) begin
         n_fail++; $display("FAIL max_len: %0d bytes eof@%0d timeout %b, expected %0d", got_data.size(), eof_at, timed_out, DFL_MAX);
      end
      n_tests++;
      if (sv_syncd !== ref_syncd(DFL_MAX, 1'b0) || err_cnt != 0) begin
         n_fail++; $display("FAIL max_syncd: got %0d expected %0d", sv_syncd, ref_syncd(DFL_MAX, 1'b0));
      end
      tick();
   endtask

   task automatic test_random();
      int  dfl;
      bit  hem;
      rand_stall = 1'b1;
      for (int f = 0; f < 12; f++) begin
         dfl = $urandom_range(1, 40);
         hem = 1'($urandom_range(0, 1));
         load(dfl + $urandom_range(0, 3), $urandom_range(0, 187));
         run_field(dfl, hem, -1);
         n_tests++;
         if (timed_out || got_data.size() != dfl || data_errors(dfl) != 0 || rd_empty_cnt != 0) begin
            n_fail++; $display("FAIL rand%0d_data: %0d bytes (dfl %0d), rd_empty %0d, timeout %b", f, got_data.size(), dfl, rd_empty_cnt, timed_out);
         end
         n_tests++;
         if (sof_cnt != 1 || sof_at != 0 || eof_cnt != 1 || eof_at != dfl - 1 || sv_syncd !== ref_syncd(dfl, hem)) begin
            n_fail++; $display("FAIL rand%0d_frame: sof %0d@%0d eof %0d@%0d syncd %0d, expected eof@%0d syncd %0d",
                               f, sof_cnt, sof_at, eof_cnt, eof_at, sv_syncd, dfl - 1, ref_syncd(dfl, hem));
         end
         if ($urandom_range(0, 1) == 1) tick();
      end
      rand_stall = 1'b0;
   endtask

   initial begin
      clear_mon();
      stall_at = 0;
      stall_len = 0;
      test_reset();
      test_nm_basic();
      test_hem();
      test_stall();
      test_err();
      test_back_to_back();
      test_reset_mid();
      test_max_len();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
